// File: rtl/lif_layer_sequencer.sv
// Time-multiplexes one shared LIF datapath across NEURONS virtual neurons.
// Holds weight rows, membranes and threshold/shift config; emits a spike vector per step.
module lif_layer_sequencer #(
    parameter int SYNAPSES       = 8,
    parameter int NEURONS        = 4,
    parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(NEURONS)-1:0]  cfg_neuron,
    input  logic [SYNAPSES-1:0]         cfg_weights,
    input  logic                        cfg_param_we,
    input  logic [2:0]                  cfg_shift,
    input  logic [THRESHOLD_BITS-1:0]   cfg_threshold,
    input  logic                        mem_clear,
    input  logic                        step_valid,
    output logic                        step_ready,
    input  logic [SYNAPSES-1:0]         step_inputs,
    output logic                        spikes_valid,
    output logic [NEURONS-1:0]          spikes,
    output logic [15:0]                 step_count,
    output logic [SYNAPSES-1:0]         dp_inputs,
    output logic [SYNAPSES-1:0]         dp_weights,
    output logic [2:0]                  dp_shift,
    output logic [THRESHOLD_BITS-1:0]   dp_threshold,
    output logic [MEMBRANE_BITS-1:0]    dp_last_membrane,
    input  logic [MEMBRANE_BITS-1:0]    dp_new_membrane,
    input  logic                        dp_is_spike
);
    // state | meaning
    // IDLE  | accepting config writes, membrane clear and new timesteps
    // RUN   | neuron idx on the shared datapath, one neuron per cycle
    // DONE  | spikes_valid pulse, step_count advances
    localparam int IDX_W = $clog2(NEURONS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_next;
    logic [IDX_W-1:0]           idx;
    logic [SYNAPSES-1:0]        weight_rows [NEURONS];
    logic [MEMBRANE_BITS-1:0]   membranes [NEURONS];
    logic [NEURONS-1:0]         spike_acc, spike_acc_next;
    logic [SYNAPSES-1:0]        inputs_q;
    logic [2:0]                 shift_q;
    logic [THRESHOLD_BITS-1:0]  threshold_q;
    logic                       step_accept;

    assign step_ready   = (state == IDLE) && !mem_clear && !reset;
    assign step_accept  = step_valid && step_ready;
    assign spikes_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (step_accept) state_next = RUN;
            RUN:     if (idx == IDX_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dp_inputs        = '0;
        dp_weights       = '0;
        dp_shift         = '0;
        dp_threshold     = '0;
        dp_last_membrane = '0;
        spike_acc_next   = spike_acc;
        if (state == RUN) begin
            dp_inputs           = inputs_q;
            dp_weights          = weight_rows[idx];
            dp_shift            = shift_q;
            dp_threshold        = threshold_q;
            dp_last_membrane    = membranes[idx];
            spike_acc_next[idx] = dp_is_spike;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            spike_acc   <= '0;
            spikes      <= '0;
            step_count  <= '0;
            inputs_q    <= '0;
            shift_q     <= '0;
            threshold_q <= '1;
            for (int i = 0; i < NEURONS; i++) begin
                weight_rows[i] <= '0;
                membranes[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // config written alongside an accepted step is seen by that step
                    if (cfg_we && (int'(cfg_neuron) < NEURONS))
                        weight_rows[cfg_neuron] <= cfg_weights;
                    if (cfg_param_we) begin
                        shift_q     <= cfg_shift;
                        threshold_q <= cfg_threshold;
                    end
                    if (mem_clear) begin
                        for (int i = 0; i < NEURONS; i++) membranes[i] <= '0;
                    end else if (step_accept) begin
                        inputs_q <= step_inputs;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    membranes[idx] <= dp_new_membrane;
                    spike_acc      <= spike_acc_next;
                    if (idx == IDX_LAST) spikes <= spike_acc_next;
                    else                 idx    <= idx + IDX_W'(1);
                end
                DONE: step_count <= step_count + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_layer_sequencer.sv
// Directed bench for lif_layer_sequencer with a popcount/threshold stub datapath.
module tb_lif_layer_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_neuron = '0;
    logic [7:0]  cfg_weights = '0;
    logic        cfg_param_we = 1'b0;
    logic [2:0]  cfg_shift = '0;
    logic [3:0]  cfg_threshold = '0;
    logic        mem_clear = 1'b0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic [7:0]  step_inputs = '0;
    logic        spikes_valid;
    logic [3:0]  spikes;
    logic [15:0] step_count;
    logic [7:0]  dp_inputs, dp_weights;
    logic [2:0]  dp_shift;
    logic [3:0]  dp_threshold;
    logic [4:0]  dp_last_membrane, dp_new_membrane;
    logic        dp_is_spike;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rows [4];
    logic [4:0] exp_last [4];
    logic [2:0] exp_shift;
    logic [3:0] exp_thr;
    int stub_sum;

    lif_layer_sequencer #(.SYNAPSES(8), .NEURONS(4), .MEMBRANE_BITS(5), .THRESHOLD_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_weights(cfg_weights),
        .cfg_param_we(cfg_param_we), .cfg_shift(cfg_shift), .cfg_threshold(cfg_threshold),
        .mem_clear(mem_clear), .step_valid(step_valid), .step_ready(step_ready),
        .step_inputs(step_inputs), .spikes_valid(spikes_valid), .spikes(spikes),
        .step_count(step_count), .dp_inputs(dp_inputs), .dp_weights(dp_weights),
        .dp_shift(dp_shift), .dp_threshold(dp_threshold), .dp_last_membrane(dp_last_membrane),
        .dp_new_membrane(dp_new_membrane), .dp_is_spike(dp_is_spike)
    );

    always #5 clk = ~clk;

    always_comb begin
        stub_sum        = int'({27'd0, dp_last_membrane}) + $countones(dp_inputs & dp_weights);
        dp_is_spike     = stub_sum >= int'({28'd0, dp_threshold});
        dp_new_membrane = dp_is_spike ? 5'd0 : stub_sum[4:0];
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cfg_row(input logic [1:0] n, input logic [7:0] w);
        cfg_we = 1'b1; cfg_neuron = n; cfg_weights = w;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_param(input logic [2:0] s, input logic [3:0] t);
        cfg_param_we = 1'b1; cfg_shift = s; cfg_threshold = t;
        tick;
        cfg_param_we = 1'b0;
    endtask

    // one full step: handshake, four RUN cycles, DONE, back to IDLE
    task automatic run_step(input logic [7:0] in, input logic [3:0] exp_spk, input logic [15:0] exp_cnt);
        step_valid = 1'b1; step_inputs = in;
        #1;
        chk("step_ready_before", 32'(step_ready), 32'd1);
        tick;
        step_valid = 1'b0; step_inputs = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dp_inputs_n%0d", i), 32'(dp_inputs), 32'(in));
            chk($sformatf("dp_weights_n%0d", i), 32'(dp_weights), 32'(exp_rows[i]));
            chk($sformatf("dp_last_n%0d", i), 32'(dp_last_membrane), 32'(exp_last[i]));
            chk($sformatf("dp_shift_n%0d", i), 32'(dp_shift), 32'(exp_shift));
            chk($sformatf("dp_thr_n%0d", i), 32'(dp_threshold), 32'(exp_thr));
            chk($sformatf("no_valid_n%0d", i), 32'(spikes_valid), 32'd0);
            tick;
        end
        chk("spikes_valid_done", 32'(spikes_valid), 32'd1);
        chk("spikes_done", 32'(spikes), 32'(exp_spk));
        chk("ready_in_done", 32'(step_ready), 32'd0);
        tick;
        chk("spikes_valid_after", 32'(spikes_valid), 32'd0);
        chk("step_count", 32'(step_count), 32'(exp_cnt));
        chk("ready_after", 32'(step_ready), 32'd1);
        chk("spikes_held", 32'(spikes), 32'(exp_spk));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic sv_seen;

        // reset
        tick; tick;
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(step_ready), 32'd1);
        chk("rst_spikes", 32'(spikes), 32'd0);
        chk("rst_valid", 32'(spikes_valid), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        chk("rst_dp_in", 32'(dp_inputs), 32'd0);
        chk("rst_dp_w", 32'(dp_weights), 32'd0);
        chk("rst_dp_shift", 32'(dp_shift), 32'd0);
        chk("rst_dp_thr", 32'(dp_threshold), 32'd0);
        chk("rst_dp_last", 32'(dp_last_membrane), 32'd0);
        exp_rows = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_last = '{5'd0, 5'd0, 5'd0, 5'd0};

        // single step
        cfg_row(2'd0, 8'hFF); exp_rows[0] = 8'hFF;
        cfg_param(3'd1, 4'd4); exp_shift = 3'd1; exp_thr = 4'd4;
        run_step(8'h0F, 4'b0001, 16'd1);

        // accumulation: n0 gains 8, n1 gains 3 per step, threshold 10
        cfg_param(3'd1, 4'd10); exp_thr = 4'd10;
        cfg_row(2'd1, 8'h07); exp_rows[1] = 8'h07;
        exp_last = '{5'd0, 5'd0, 5'd0, 5'd0}; run_step(8'hFF, 4'b0000, 16'd2);
        exp_last = '{5'd8, 5'd3, 5'd0, 5'd0}; run_step(8'hFF, 4'b0001, 16'd3);
        exp_last = '{5'd0, 5'd6, 5'd0, 5'd0}; run_step(8'hFF, 4'b0000, 16'd4);
        exp_last = '{5'd8, 5'd9, 5'd0, 5'd0}; run_step(8'hFF, 4'b0011, 16'd5);
        exp_last = '{5'd0, 5'd0, 5'd0, 5'd0}; run_step(8'hFF, 4'b0000, 16'd6);

        // back-pressure with ignored row write during RUN; membranes now n0=8, n1=3
        step_valid = 1'b1; step_inputs = 8'h00; t0 = -1; t1 = -1;
        for (int c = 0; c < 30 && t1 < 0; c++) begin
            cfg_we = (t0 >= 0 && c == t0 + 1); cfg_neuron = 2'd0; cfg_weights = 8'h00;
            #1;
            if (step_ready) begin
                if (t0 < 0) t0 = c;
                else        t1 = c;
            end
            tick;
        end
        step_valid = 1'b0; cfg_we = 1'b0;
        chk("bp_spacing", 32'(t1 - t0), 32'd6);
        chk("bp_row0_kept", 32'(dp_weights), 32'hFF);
        chk("bp_n0_last", 32'(dp_last_membrane), 32'd8);
        tick; tick; tick; tick; tick;
        chk("bp_count", 32'(step_count), 32'd8);
        chk("bp_ready", 32'(step_ready), 32'd1);

        // clear priority over a step
        mem_clear = 1'b1; step_valid = 1'b1; step_inputs = 8'h00;
        #1;
        chk("clr_blocks_ready", 32'(step_ready), 32'd0);
        tick;
        mem_clear = 1'b0;
        exp_last = '{5'd0, 5'd0, 5'd0, 5'd0};
        run_step(8'h00, 4'b0000, 16'd9);

        // reset mid-RUN at idx 2
        step_valid = 1'b1; step_inputs = 8'hFF;
        tick;
        step_valid = 1'b0;
        tick; tick;
        chk("mid_idx2_row", 32'(dp_weights), 32'h00);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("mid_ready", 32'(step_ready), 32'd1);
        chk("mid_valid", 32'(spikes_valid), 32'd0);
        chk("mid_count", 32'(step_count), 32'd0);
        chk("mid_spikes", 32'(spikes), 32'd0);
        sv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sv_seen = sv_seen | spikes_valid;
            tick;
        end
        chk("mid_no_pulse", 32'(sv_seen), 32'd0);
        exp_rows = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_last = '{5'd0, 5'd0, 5'd0, 5'd0};
        exp_shift = 3'd0; exp_thr = 4'hF;
        run_step(8'hFF, 4'b0000, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
